// File: rtl/uart_alu_intf.sv
// uart_alu_intf: pops 3-byte commands (A, B, OP) from the UART rx FIFO,
// presents them as registered ALU operands, and pushes the captured ALU
// result into the UART tx FIFO. A partial command is dropped if the rx FIFO
// stays empty for TO_CYC consecutive cycles while waiting for B or OP.
module uart_alu_intf #(
  parameter int DBIT   = 8,
  parameter int OP_W   = 6,
  parameter int TO_CYC = 1_000_000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_cmd_done,
  output logic            o_timeout
);

  localparam int            CW      = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND
  } state_t;

  state_t          state;
  logic [DBIT-1:0] a_reg;
  logic [DBIT-1:0] b_reg;
  logic [OP_W-1:0] op_reg;
  logic [DBIT-1:0] result_reg;
  logic [CW-1:0]   to_cnt;
  logic            timeout_reg;
  logic            in_get;

  // FIFO strobes are combinational so a waiting byte is popped with no added latency;
  // gating with reset keeps both strobes low while reset is held.
  always_comb begin
    in_get    = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    o_rd_uart = i_reset && in_get && !i_rx_empty;
    o_wr_uart = i_reset && (state == SEND) && !i_tx_full;
  end

  assign o_cmd_done = o_wr_uart;
  assign o_w_data   = result_reg;
  assign o_alu_a    = a_reg;
  assign o_alu_b    = b_reg;
  assign o_alu_op   = op_reg;
  assign o_timeout  = timeout_reg;

  // Command FSM: collect A, B, OP, give the ALU one cycle, then push the result.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= GET_A;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      result_reg  <= '0;
      to_cnt      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state)
        GET_A: begin
          to_cnt <= '0;
          if (!i_rx_empty) begin
            a_reg <= i_r_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (!i_rx_empty) begin
            b_reg  <= i_r_data;
            to_cnt <= '0;
            state  <= GET_OP;
          end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            timeout_reg <= 1'b1;
            state       <= GET_A;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GET_OP: begin
          if (!i_rx_empty) begin
            op_reg <= i_r_data[OP_W-1:0];
            to_cnt <= '0;
            state  <= EXEC;
          end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            timeout_reg <= 1'b1;
            state       <= GET_A;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EXEC: begin
          to_cnt     <= '0;
          result_reg <= i_alu_result;
          state      <= SEND;
        end
        SEND: begin
          to_cnt <= '0;
          if (!i_tx_full) begin
            state <= GET_A;
          end
        end
        default: begin
          to_cnt <= '0;
          state  <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// tb_uart_alu_intf: directed bench for uart_alu_intf with an rx FIFO model,
// a small ALU, a command-level reference model and a per-cycle compare process.
module tb_uart_alu_intf;

  localparam int TB_TO = 20;

  logic       i_clk;
  logic       i_reset;
  logic       i_rx_empty;
  logic [7:0] i_r_data;
  logic       o_rd_uart;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_w_data;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_cmd_done;
  logic       o_timeout;

  uart_alu_intf #(.DBIT(8), .OP_W(6), .TO_CYC(TB_TO)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_empty   (i_rx_empty),
    .i_r_data     (i_r_data),
    .o_rd_uart    (o_rd_uart),
    .i_tx_full    (i_tx_full),
    .o_wr_uart    (o_wr_uart),
    .o_w_data     (o_w_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_cmd_done   (o_cmd_done),
    .o_timeout    (o_timeout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } cmd_t;

  int   total = 0;
  int   bad = 0;
  int   push_count = 0;
  int   to_count = 0;
  int   to_gap = -1;
  int   last_pop_cyc = 0;
  int   cyc = 0;
  logic [7:0] last_data = '0;
  cmd_t exp_q[$];

  logic [7:0] rx_mem [0:63];
  int   rd_ptr = 0;
  int   wr_ptr = 0;

  int   m_bytes = 0;
  logic m_exec = 1'b0;
  int   m_idle = 0;
  logic m_to = 1'b0;

  // Bench ALU: 0x20 add, 0x22 subtract, 0x24 and, anything else xor.
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);
  assign i_rx_empty   = (rd_ptr == wr_ptr);
  assign i_r_data     = rx_mem[rd_ptr];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // rx FIFO model: the head advances on every edge the DUT pops.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rd_uart) rd_ptr <= rd_ptr + 1;
  end

  // Reference model: bytes collected toward the current command, whether the
  // one-cycle ALU slot has passed, and how long a partial command has starved.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_bytes <= 0;
      m_exec  <= 1'b0;
      m_idle  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_bytes == 3) begin
        m_idle <= 0;
        if (!m_exec) m_exec <= 1'b1;
        else if (!i_tx_full) begin
          m_bytes <= 0;
          m_exec  <= 1'b0;
        end
      end else if (!i_rx_empty) begin
        m_bytes <= m_bytes + 1;
        m_idle  <= 0;
      end else if (m_bytes != 0) begin
        if (m_idle == TB_TO - 1) begin
          m_bytes <= 0;
          m_idle  <= 0;
          m_to    <= 1'b1;
        end else begin
          m_idle <= m_idle + 1;
        end
      end else begin
        m_idle <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Per-cycle compare against the model plus the push scoreboard.
  always @(negedge i_clk) begin
    if (i_reset) begin
      checkOutput("rd_uart", o_rd_uart, (!i_rx_empty && m_bytes < 3));
      checkOutput("wr_uart", o_wr_uart, (m_bytes == 3 && m_exec && !i_tx_full));
      checkOutput("cmd_done", o_cmd_done, (m_bytes == 3 && m_exec && !i_tx_full));
      checkOutput("timeout", o_timeout, m_to);
      if (o_rd_uart) last_pop_cyc = cyc + 1;
      if (o_timeout) begin
        to_count++;
        to_gap = cyc - last_pop_cyc;
      end
      if (o_wr_uart) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_push", 1, 0);
        end else begin
          cmd_t e;
          e = exp_q.pop_front();
          checkOutput("w_data", o_w_data, e.res);
          checkOutput("alu_a", o_alu_a, e.a);
          checkOutput("alu_b", o_alu_b, e.b);
          checkOutput("alu_op", o_alu_op, e.op);
        end
        last_data = o_w_data;
        push_count++;
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    rx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    cmd_t e;
    e.a   = a;
    e.b   = b;
    e.op  = op[5:0];
    e.res = alu(a, b, op[5:0]);
    exp_q.push_back(e);
    pushByte(a);
    pushByte(b);
    pushByte(op);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic waitPushes(input int target, input int budget, input string name);
    int n = 0;
    while (push_count < target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    step(1);
    checkOutput({name, "_pushes"}, push_count, target);
  endtask

  initial begin
    i_reset   = 1'b0;
    i_tx_full = 1'b0;
    step(3);
    checkOutput("rst_alu_a", o_alu_a, 8'h00);
    checkOutput("rst_alu_op", o_alu_op, 6'h00);
    checkOutput("rst_w_data", o_w_data, 8'h00);
    checkOutput("rst_wr_uart", o_wr_uart, 1'b0);
    i_reset = 1'b1;
    step(2);

    $display("[TB] add command");
    applyStimulus(8'h05, 8'h03, 8'h20);
    waitPushes(1, 20, "add");
    checkOutput("add_op", o_alu_op, 6'h20);
    checkOutput("add_result", last_data, 8'h08);

    $display("[TB] sub with upper opcode bits set");
    applyStimulus(8'h10, 8'h01, 8'hE2);
    waitPushes(2, 20, "sub");
    checkOutput("sub_op", o_alu_op, 6'h22);
    checkOutput("sub_result", last_data, 8'h0F);

    $display("[TB] tx full back-pressure");
    i_tx_full = 1'b1;
    applyStimulus(8'h30, 8'h0C, 8'h20);
    step(10);
    checkOutput("held_result", o_w_data, 8'h3C);
    step(40);
    checkOutput("no_push_while_full", push_count, 2);
    i_tx_full = 1'b0;
    waitPushes(3, 5, "full");
    checkOutput("full_result", last_data, 8'h3C);

    $display("[TB] inter-byte timeout");
    pushByte(8'hAA);
    begin
      int n = 0;
      while (to_count < 1 && n < 40) begin
        @(negedge i_clk);
        n++;
      end
    end
    step(1);
    checkOutput("timeout_seen", to_count, 1);
    checkOutput("timeout_gap", to_gap, TB_TO);
    checkOutput("timeout_a_kept", o_alu_a, 8'hAA);
    checkOutput("timeout_no_push", push_count, 3);
    applyStimulus(8'h01, 8'h02, 8'h20);
    waitPushes(4, 20, "after_to");
    checkOutput("after_to_result", last_data, 8'h03);

    $display("[TB] reset mid-command");
    pushByte(8'h09);
    pushByte(8'h04);
    step(4);
    i_reset = 1'b0;
    #1;
    checkOutput("mid_rst_alu_a", o_alu_a, 8'h00);
    checkOutput("mid_rst_alu_b", o_alu_b, 8'h00);
    checkOutput("mid_rst_alu_op", o_alu_op, 6'h00);
    checkOutput("mid_rst_w_data", o_w_data, 8'h00);
    checkOutput("mid_rst_rd_uart", o_rd_uart, 1'b0);
    checkOutput("mid_rst_timeout", o_timeout, 1'b0);
    step(2);
    i_reset = 1'b1;
    step(1);
    applyStimulus(8'h07, 8'h01, 8'h20);
    waitPushes(5, 20, "post_rst");
    checkOutput("post_rst_result", last_data, 8'h08);

    $display("[TB] two queued commands");
    applyStimulus(8'h11, 8'h22, 8'h20);
    applyStimulus(8'h50, 8'h10, 8'h22);
    waitPushes(7, 30, "pair");
    checkOutput("pair_last_result", last_data, 8'h40);

    step(5);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("timeout_total", to_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
